scaled_addsub_seq: RTL and testbench
====================================

# scaled_addsub_seq

Parametrised sequential linear-combination unit computing `KA*A + KB*B` or `KA*A - KB*B` over WIDTH-bit operands with run-time coefficients. It is the general successor to the fixed-coefficient 16-bit adder/subtractor datapath. It works by serial shift-and-add, one coefficient bit per cycle, in an exact-width accumulator. It sits behind a valid/ready handshake and reports carry, borrow and overflow against the WIDTH-bit result.

## Interface
- WIDTH, 16, operand and result width (≥2)
- COEF_W, 4, coefficient width (≥1), unsigned coefficients
- clk  in  1  rising-edge clock, the only clock
- rst_n  in  1  reset, synchronous and active-low
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- A, B  in  WIDTH  operands
- KA, KB  in  COEF_W  unsigned coefficients
- sub  in  1  0: `KA*A + KB*B`; 1: `KA*A - KB*B`
- s  in  1  1: operands signed two's complement; 0: unsigned
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- Output  out  WIDTH  exact result mod 2^WIDTH
- Carry, Borrow, Overflow  out  1 each  range flags (see Operation)
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, MUL_A, MUL_B, DONE.
- IDLE: in_ready=1. When in_valid && in_ready, capture A, B, KA, KB, sub and s; clear the accumulator; set i=0; go to MUL_A.
- Input changes after capture are ignored.
- Operands are extended to EXT_W = WIDTH+COEF_W+2 bits. Sign-extend when s=1, zero-extend when s=0.
- MUL_A, per cycle: `acc += KA[i] ? (A_ext << i) : 0`. i increments each cycle. After i=COEF_W-1, reset i to 0 and go to MUL_B.
- MUL_B, per cycle: `acc ±= KB[i] ? (B_ext << i) : 0`, using − when sub=1. After i=COEF_W-1, go to DONE.
- acc is the exact signed value; no wrap is possible in EXT_W bits.
- DONE:
  - out_valid=1.
  - Output = acc[WIDTH-1:0].
  - Unsigned (s=0): Carry = acc > 2^WIDTH−1; Borrow = acc < 0; Overflow = 0.
  - Signed (s=1): Overflow = acc outside [−2^(WIDTH−1), 2^(WIDTH−1)−1]; Carry = Borrow = 0.
  - When out_ready=1, go to IDLE.
- Zero coefficients still take the full schedule; there is no early exit.
- in_ready=0 in MUL_A, MUL_B and DONE. Only one request is in flight.

## Timing
- Reset (rst_n=0 at an edge):
  - State goes to IDLE and the accumulator clears.
  - Output, Carry, Borrow, Overflow, out_valid and busy go to 0; in_ready goes to 1 after the edge.
  - Reset applied mid-operation aborts the operation; no result is produced.
- Accept at edge T. The unit is in MUL_A for cycles T+1..T+COEF_W and in MUL_B for cycles T+COEF_W+1..T+2·COEF_W.
- out_valid rises after edge T+2·COEF_W+1. Latency is fixed at 2·COEF_W+1 cycles.
- Output and flags are registered and stay stable while out_valid=1 && out_ready=0.
- Result is consumed at edge R. In IDLE after R, in_ready=1 and outputs hold their last values with out_valid=0. The earliest next accept is at edge R+1.
- out_ready sampled while out_valid=0 is ignored.

## Structure
- Package `scaled_addsub_pkg`:
  - state enum (IDLE, MUL_A, MUL_B, DONE);
  - function `ext_w(WIDTH, COEF_W)`;
  - flag-derivation function (acc, s) → {Carry, Borrow, Overflow}.
- Sub-module `addsub_nbit` (parameter N): combinational N-bit add/subtract using the invert-B-plus-carry-in scheme, instantiated at N=EXT_W for the accumulator update.
- Top level holds the FSM, capture registers, coefficient index counter ($clog2(COEF_W) bits, minimum 1) and output registers.

## Test plan
- WIDTH=16, COEF_W=4, s=1, sub=1, A=5, KA=3, B=4, KB=2 → Output=0x0007, all flags 0, out_valid exactly 9 cycles after accept.
- s=0, sub=0, A=0xFFFF, KA=15, KB=0 → Output=0xFFF1, Carry=1, Borrow=0.
- s=0, sub=1, A=1, KA=1, B=2, KB=1 → Output=0xFFFF, Borrow=1, Carry=0.
- s=1, sub=0, A=0x4000, KA=2, KB=0 → Output=0x8000, Overflow=1. Then s=1, sub=1, A=0xFFFD, KA=3, B=2, KB=2 → Output=0xFFF3, Overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → Output and flags stable, in_ready=0, a new in_valid is not accepted. Release → IDLE next cycle, in_ready=1.
- Reset mid-MUL_B (rst_n=0 for one edge) → all outputs 0 and in_ready=1 after that edge. A following request A=5, KA=3, B=4, KB=2, sub=1, s=1 yields 0x0007 with normal latency.

Source files
------------

// File: rtl/scaled_addsub_pkg.sv
// ============================================================================
// Module : scaled_addsub_pkg
// Brief  : Shared types and helpers for the scaled add/subtract unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package scaled_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MUL_A = 2'd1,
      MUL_B = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic carry;
      logic borrow;
      logic overflow;
   } flags_t;

   localparam int FLAG_ACC_W = 64;

   function automatic int ext_w(input int width, input int coef_w);
      return width + coef_w + 2;
   endfunction

   // acc arrives sign-extended to 64 bits so one function serves every WIDTH.
   function automatic flags_t derive_flags(input logic signed [FLAG_ACC_W-1:0] acc,
                                           input logic s,
                                           input int width);
      logic signed [FLAG_ACC_W-1:0] hi_u;
      logic signed [FLAG_ACC_W-1:0] hi_s;
      logic signed [FLAG_ACC_W-1:0] lo_s;
      flags_t f;
      hi_u = (64'sd1 <<< width) - 64'sd1;
      hi_s = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo_s = -(64'sd1 <<< (width - 1));
      f    = '0;
      if (s) begin
         f.overflow = (acc < lo_s) || (acc > hi_s);
      end else begin
         f.carry  = (acc > hi_u);
         f.borrow = (acc < 64'sd0);
      end
      return f;
   endfunction

endpackage

`default_nettype wire

// File: rtl/scaled_addsub_seq_addsub.sv
// ============================================================================
// Module : addsub_nbit
// Brief  : Combinational N-bit adder/subtractor (invert B, carry in = sub).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module addsub_nbit #(
   parameter int N = 8
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic         i_sub,
   output logic [N-1:0] o_y
);

   logic [N-1:0] w_b_eff;

   assign w_b_eff = i_b ^ {N{i_sub}};
   assign o_y     = i_a + w_b_eff + {{(N-1){1'b0}}, i_sub};

endmodule

`default_nettype wire

// File: rtl/scaled_addsub_seq.sv
// ============================================================================
// Module : scaled_addsub_seq
// Brief  : Serial shift-and-add unit computing KA*A +/- KB*B with range flags.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module scaled_addsub_seq
   import scaled_addsub_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int COEF_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  A,
   input  logic [WIDTH-1:0]  B,
   input  logic [COEF_W-1:0] KA,
   input  logic [COEF_W-1:0] KB,
   input  logic              sub,
   input  logic              s,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  Output,
   output logic              Carry,
   output logic              Borrow,
   output logic              Overflow,
   output logic              busy
);

   localparam int EXT_W = ext_w(WIDTH, COEF_W);
   localparam int IDX_W = (COEF_W > 1) ? $clog2(COEF_W) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COEF_W - 1);

   state_t r_state;
   state_t w_state_nxt;

   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [COEF_W-1:0] r_ka;
   logic [COEF_W-1:0] r_kb;
   logic              r_sub;
   logic              r_s;
   logic [IDX_W-1:0]  r_idx;
   logic [EXT_W-1:0]  r_acc;

   logic [WIDTH-1:0]  r_output;
   logic              r_carry;
   logic              r_borrow;
   logic              r_overflow;
   logic              r_out_valid;

   logic [EXT_W-1:0]  w_a_ext;
   logic [EXT_W-1:0]  w_b_ext;
   logic [EXT_W-1:0]  w_addend;
   logic              w_sub_op;
   logic [EXT_W-1:0]  w_sum;
   logic              w_last;
   logic              w_accept;
   logic signed [FLAG_ACC_W-1:0] w_acc64;
   flags_t            w_flags;

   assign w_a_ext  = r_s ? {{(EXT_W-WIDTH){r_a[WIDTH-1]}}, r_a} : {{(EXT_W-WIDTH){1'b0}}, r_a};
   assign w_b_ext  = r_s ? {{(EXT_W-WIDTH){r_b[WIDTH-1]}}, r_b} : {{(EXT_W-WIDTH){1'b0}}, r_b};
   assign w_last   = (r_idx == LAST_IDX);
   assign w_accept = (r_state == IDLE) && in_valid;
   assign w_sub_op = (r_state == MUL_B) && r_sub;
   assign w_acc64  = {{(FLAG_ACC_W-EXT_W){r_acc[EXT_W-1]}}, r_acc};
   assign w_flags  = derive_flags(w_acc64, r_s, WIDTH);

   always_comb begin
      w_addend = '0;
      if (r_state == MUL_A && r_ka[r_idx]) begin
         w_addend = w_a_ext << r_idx;
      end else if (r_state == MUL_B && r_kb[r_idx]) begin
         w_addend = w_b_ext << r_idx;
      end
   end

   addsub_nbit #(.N(EXT_W)) u_addsub (
      .i_a   (r_acc),
      .i_b   (w_addend),
      .i_sub (w_sub_op),
      .o_y   (w_sum)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid)                   w_state_nxt = MUL_A;
         MUL_A:   if (w_last)                     w_state_nxt = MUL_B;
         MUL_B:   if (w_last)                     w_state_nxt = DONE;
         DONE:    if (r_out_valid && out_ready)   w_state_nxt = IDLE;
         default:                                 w_state_nxt = IDLE;
      endcase
   end

   // DONE spends one cycle registering the result before out_valid rises.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a         <= '0;
         r_b         <= '0;
         r_ka        <= '0;
         r_kb        <= '0;
         r_sub       <= 1'b0;
         r_s         <= 1'b0;
         r_idx       <= '0;
         r_acc       <= '0;
         r_output    <= '0;
         r_carry     <= 1'b0;
         r_borrow    <= 1'b0;
         r_overflow  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_a   <= A;
                  r_b   <= B;
                  r_ka  <= KA;
                  r_kb  <= KB;
                  r_sub <= sub;
                  r_s   <= s;
                  r_idx <= '0;
                  r_acc <= '0;
               end
            end
            MUL_A, MUL_B: begin
               r_acc <= w_sum;
               r_idx <= w_last ? '0 : r_idx + 1'b1;
            end
            DONE: begin
               if (!r_out_valid) begin
                  r_output    <= r_acc[WIDTH-1:0];
                  r_carry     <= w_flags.carry;
                  r_borrow    <= w_flags.borrow;
                  r_overflow  <= w_flags.overflow;
                  r_out_valid <= 1'b1;
               end else if (out_ready) begin
                  r_out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign busy      = (r_state != IDLE);
   assign out_valid = r_out_valid;
   assign Output    = r_output;
   assign Carry     = r_carry;
   assign Borrow    = r_borrow;
   assign Overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_scaled_addsub_seq.sv
// ============================================================================
// Module : tb_scaled_addsub_seq
// Brief  : Self-checking bench for scaled_addsub_seq (WIDTH=16, COEF_W=4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_scaled_addsub_seq;

   localparam int W  = 16;
   localparam int CW = 4;
   localparam int LATENCY = 2*CW + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  A, B;
   logic [CW-1:0] KA, KB;
   logic          sub, s;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  Output;
   logic          Carry, Borrow, Overflow;
   logic          busy;

   always #5 clk = ~clk;

   scaled_addsub_seq #(.WIDTH(W), .COEF_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .KA        (KA),
      .KB        (KB),
      .sub       (sub),
      .s         (s),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Output    (Output),
      .Carry     (Carry),
      .Borrow    (Borrow),
      .Overflow  (Overflow),
      .busy      (busy)
   );

   typedef struct {
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [CW-1:0] ka;
      logic [CW-1:0] kb;
      logic          sub;
      logic          s;
      logic [W-1:0]  out;
      logic          c;
      logic          bo;
      logic          ov;
   } vec_t;

   vec_t tbl[7];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // Exact integer arithmetic straight from the definition of the result.
   function automatic vec_t model(input vec_t v);
      vec_t   r;
      longint av, bv, acc;
      r   = v;
      av  = v.s ? longint'($signed(v.a)) : longint'(v.a);
      bv  = v.s ? longint'($signed(v.b)) : longint'(v.b);
      acc = v.sub ? longint'(v.ka) * av - longint'(v.kb) * bv
                  : longint'(v.ka) * av + longint'(v.kb) * bv;
      r.out = acc[W-1:0];
      r.c   = !v.s && (acc > 65535);
      r.bo  = !v.s && (acc < 0);
      r.ov  = v.s && ((acc < -32768) || (acc > 32767));
      return r;
   endfunction

   task automatic issue(input vec_t v);
      int k;
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
      A = v.a; B = v.b; KA = v.ka; KB = v.kb; sub = v.sub; s = v.s;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      A   = W'($urandom);
      B   = W'($urandom);
      KA  = CW'($urandom);
      KB  = CW'($urandom);
      sub = 1'($urandom);
      s   = 1'($urandom);
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic check_result(input string tag, input vec_t v);
      chk({tag, ".Output"},   {16'd0, Output},      {16'd0, v.out});
      chk({tag, ".Carry"},    {31'd0, Carry},       {31'd0, v.c});
      chk({tag, ".Borrow"},   {31'd0, Borrow},      {31'd0, v.bo});
      chk({tag, ".Overflow"}, {31'd0, Overflow},    {31'd0, v.ov});
   endtask

   task automatic consume(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, ".in_ready_after_consume"},  {31'd0, in_ready},  32'd1);
      chk({tag, ".out_valid_after_consume"}, {31'd0, out_valid}, 32'd0);
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      int lat;
      issue(v);
      wait_valid(lat);
      chk({tag, ".latency"}, lat, LATENCY);
      check_result(tag, v);
      consume(tag);
   endtask

   initial begin
      vec_t v;
      int   lat;
      bit   seen;

      tbl[0] = '{a:16'd5,    b:16'd4,    ka:4'd3,  kb:4'd2,  sub:1'b1, s:1'b1, out:16'h0007, c:1'b0, bo:1'b0, ov:1'b0};
      tbl[1] = '{a:16'hFFFF, b:16'h1234, ka:4'd15, kb:4'd0,  sub:1'b0, s:1'b0, out:16'hFFF1, c:1'b1, bo:1'b0, ov:1'b0};
      tbl[2] = '{a:16'd1,    b:16'd2,    ka:4'd1,  kb:4'd1,  sub:1'b1, s:1'b0, out:16'hFFFF, c:1'b0, bo:1'b1, ov:1'b0};
      tbl[3] = '{a:16'h4000, b:16'h7777, ka:4'd2,  kb:4'd0,  sub:1'b0, s:1'b1, out:16'h8000, c:1'b0, bo:1'b0, ov:1'b1};
      tbl[4] = '{a:16'hFFFD, b:16'd2,    ka:4'd3,  kb:4'd2,  sub:1'b1, s:1'b1, out:16'hFFF3, c:1'b0, bo:1'b0, ov:1'b0};
      tbl[5] = '{a:16'h8000, b:16'h8000, ka:4'd15, kb:4'd15, sub:1'b0, s:1'b1, out:16'h0000, c:1'b0, bo:1'b0, ov:1'b1};
      tbl[6] = '{a:16'h0000, b:16'hFFFF, ka:4'd0,  kb:4'd15, sub:1'b1, s:1'b0, out:16'h000F, c:1'b0, bo:1'b1, ov:1'b0};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      A = '0; B = '0; KA = '0; KB = '0; sub = 1'b0; s = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset.Output",    {16'd0, Output},    32'd0);
      chk("reset.flags",     {29'd0, Carry, Borrow, Overflow}, 32'd0);
      chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset.busy",      {31'd0, busy},      32'd0);
      chk("reset.in_ready",  {31'd0, in_ready},  32'd1);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         run_vec($sformatf("tbl%0d", i), tbl[i]);
      end

      // Backpressure: result must hold and new requests must be refused.
      issue(tbl[1]);
      wait_valid(lat);
      chk("bp.latency", lat, LATENCY);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         in_valid = 1'b1;
         A  = W'($urandom);
         KA = CW'($urandom);
         @(posedge clk);
         #1;
         chk($sformatf("bp%0d.out_valid", k), {31'd0, out_valid}, 32'd1);
         chk($sformatf("bp%0d.in_ready", k),  {31'd0, in_ready},  32'd0);
         check_result($sformatf("bp%0d", k), tbl[1]);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("bp.release.in_ready",  {31'd0, in_ready},  32'd1);
      chk("bp.release.out_valid", {31'd0, out_valid}, 32'd0);
      chk("bp.release.busy",      {31'd0, busy},      32'd0);
      chk("bp.release.hold",      {16'd0, Output},    {16'd0, tbl[1].out});

      // Reset during MUL_B aborts the operation.
      issue(tbl[3]);
      repeat (6) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst.Output",    {16'd0, Output},    32'd0);
      chk("midrst.flags",     {29'd0, Carry, Borrow, Overflow}, 32'd0);
      chk("midrst.out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst.busy",      {31'd0, busy},      32'd0);
      chk("midrst.in_ready",  {31'd0, in_ready},  32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      chk("midrst.no_result", {31'd0, seen}, 32'd0);
      run_vec("post_rst", tbl[0]);

      // Randomised requests against the arithmetic model.
      for (int i = 0; i < 40; i++) begin
         v.a   = W'($urandom);
         v.b   = W'($urandom);
         v.ka  = CW'($urandom);
         v.kb  = CW'($urandom);
         v.sub = 1'($urandom);
         v.s   = 1'($urandom);
         v     = model(v);
         run_vec($sformatf("rnd%0d", i), v);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
